prog_mem: RTL
=============

# prog_mem

Parametrised, loadable program memory that replaces the fixed 16×16 instruction ROM. It sits between the external program loader and the processor fetch stage. After reset it clears its contents to NOP, then serves registered instruction fetches. It can be reloaded at run time through a valid/ready streaming port, and pads any short program with NOPs.

## Interface
- `DATA_W`, 16, instruction width in bits
- `ADDR_W`, 4, address width; depth `DEPTH = 2**ADDR_W` words
- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `load_start`  in  1  one-cycle request to begin reload; honoured only in RUN
- `load_valid`  in  1  loader word valid
- `load_data`  in  DATA_W  loader word
- `load_last`  in  1  qualifies final word of program; sampled with `load_valid`
- `load_par`  in  1  even parity of `load_data`; used only when parity is compiled in
- `load_ready`  out  1  block accepts a word this cycle
- `load_done`  out  1  one-cycle pulse on return to RUN after a reload
- `load_err`  out  1  sticky parity error; cleared by accepted `load_start`
- `fetch_req`  in  1  fetch request
- `fetch_addr`  in  ADDR_W  fetch address
- `fetch_valid`  out  1  `instruction` is valid this cycle
- `instruction`  out  DATA_W  registered fetch data
- `busy`  out  1  high in every state except RUN

## Operation
- FSM states: CLEAR, RUN, LOAD, FILL.
- Reset: FSM to CLEAR, write pointer `wp` = 0. Outputs: `load_ready` 0, `load_done` 0, `load_err` 0, `fetch_valid` 0, `instruction` 0, `busy` 1.
- CLEAR: writes 0 to `mem[wp]` and increments `wp` every cycle. When `wp` = DEPTH-1 is written, the FSM moves to RUN and `wp` wraps to 0.
- RUN: if `fetch_req` = 1, `instruction` <= `mem[fetch_addr]` and `fetch_valid` <= 1 next cycle; otherwise `fetch_valid` <= 0 and `instruction` holds. If `load_start` = 1, the FSM moves to LOAD, `wp` is set to 0 and `load_err` is set to 0.
- LOAD: `load_ready` = 1. A transfer occurs on `load_valid & load_ready`: `mem[wp]` <= `load_data` and `wp`++.
  - Transfer with `load_last` and `wp` < DEPTH-1: go to FILL.
  - Transfer at `wp` = DEPTH-1, with or without `load_last`: go to RUN with `load_done` pulse and `wp` wraps to 0.
- FILL: writes 0 to the remaining words, one per cycle, through `wp` = DEPTH-1. Then go to RUN with `load_done` pulse.
- Outside RUN: `fetch_req` is ignored and `fetch_valid` = 0. Outside LOAD: `load_valid` is ignored. `load_start` is ignored outside RUN.
- Simultaneous `fetch_req` and `load_start` in RUN: the fetch is serviced, and `fetch_valid` and old data appear the next cycle while the FSM is in LOAD.
- `rst_n` low mid-LOAD or mid-FILL: immediate return to CLEAR. Partial contents are discarded by the clear.

## Timing
- Fetch latency: 1 cycle, request to `fetch_valid`. Back-to-back fetches give one result per cycle.
- CLEAR takes DEPTH cycles after `rst_n` deasserts. The first fetch can be accepted in cycle DEPTH.
- Reload time: 1 cycle (`load_start`), then N transfer cycles, then DEPTH-N FILL cycles when N < DEPTH. `load_done` is high in the first RUN cycle.
- `load_ready` is combinational from state only, with no dependence on `load_valid`.
- Memory write and read in the same cycle cannot occur, because fetch and writes are in exclusive states.

## Configuration
- `PROG_MEM_PARITY_EN` defined:
  - On each transfer, the block checks `^load_data ^ load_par`. On a mismatch, it stores 0 (NOP) at `mem[wp]` instead of the word and sets `load_err`.
  - The word still counts toward `wp`.
- Not defined: `load_par` is unused, the word is always stored, and `load_err` is tied to 0.

## Test plan
- Reset, then idle for 16 cycles; fetch addresses 0..15 back to back -> `busy` falls after 16 cycles, `fetch_valid` follows each request by 1 cycle, and every `instruction` = 16'h0000.
- Full load of 16 words 16'hA000+i with `load_valid` held high -> `load_done` pulses once after the 16th transfer, and fetch of address i returns 16'hA000+i.
- Short load of 3 words (16'h1E08, 16'h1201, 16'h3448) with `load_last` on the 3rd -> 13 FILL cycles, then `load_done`. Addresses 0..2 return the loaded words and addresses 3..15 return 0.
- `load_valid` toggled every other cycle, plus `load_start` asserted in the same cycle as a fetch of address 2 -> the fetch returns the old `mem[2]` one cycle later, and only cycles with `load_ready & load_valid` advance `wp`.
- `rst_n` pulsed low after 5 load transfers -> `busy` stays high, CLEAR runs for 16 cycles, then all addresses read 0 and `load_done` never pulses.
- With `PROG_MEM_PARITY_EN` defined: word 2 sent with wrong `load_par` -> `load_err` = 1 and stays high, `mem[2]` = 0, and other words load normally. The next `load_start` clears `load_err`.

Source files
------------

// File: rtl/prog_mem.sv
// Loadable program memory: clears to NOP after reset, serves registered fetches,
// reloads through a valid/ready port. Define PROG_MEM_PARITY_EN for loader parity checking.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLEAR | writing NOP to every word after reset, wp sweeps 0..DEPTH-1
// S_RUN   | serving fetches, waiting for load_start
// S_LOAD  | accepting loader words at wp
// S_FILL  | padding the rest of a short program with NOP
module prog_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_par,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] WP_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_FILL  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wp;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              xfer;
    logic              par_bad;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    assign load_ready = (state == S_LOAD);
    assign busy       = (state != S_RUN);
    assign xfer       = load_ready & load_valid;

`ifdef PROG_MEM_PARITY_EN
    assign par_bad = ^load_data ^ load_par;
`else
    logic unused_par;
    assign par_bad    = 1'b0;
    assign unused_par = load_par;
`endif

    // A word with bad parity is replaced by NOP but still consumes its slot.
    assign mem_we    = (state == S_CLEAR) | (state == S_FILL) | xfer;
    assign mem_wdata = (xfer && !par_bad) ? load_data : '0;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wp] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_CLEAR;
            wp        <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                S_CLEAR: begin
                    wp <= wp + 1'b1;
                    if (wp == WP_LAST)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (load_start) begin
                        state <= S_LOAD;
                        wp    <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        wp <= wp + 1'b1;
                        if (wp == WP_LAST) begin
                            state     <= S_RUN;
                            load_done <= 1'b1;
                        end else if (load_last) begin
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    wp <= wp + 1'b1;
                    if (wp == WP_LAST) begin
                        state     <= S_RUN;
                        load_done <= 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            instruction <= '0;
        end else if (state == S_RUN && fetch_req) begin
            fetch_valid <= 1'b1;
            instruction <= mem[fetch_addr];
        end else begin
            fetch_valid <= 1'b0;
        end
    end

`ifdef PROG_MEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_err <= 1'b0;
        else if (state == S_RUN && load_start)
            load_err <= 1'b0;
        else if (xfer && par_bad)
            load_err <= 1'b1;
    end
`else
    assign load_err = 1'b0;
`endif

endmodule
